hazard_unit: RTL and testbench

//  Pipeline control responder for the ID/EX, IF/ID, EX/MEM and MEM/WB registers: drives

---
 rtl/cpu_types_pkg.sv | 9 +
 rtl/data_path_muxs_pkg.sv | 61 ++++++
 rtl/sat_counter.sv | 25 ++
 rtl/hazard_unit.sv | 134 +++++++++++++
 tb/tb_hazard_unit.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types used across pipeline blocks.
// Register-number width is fixed by the 32-entry register file.
package cpu_types_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] regbits_t;

endpackage

// File: rtl/data_path_muxs_pkg.sv
// Hazard-unit state encoding, pipeline control bundle and the load-use detector
// shared between the hazard unit and anything that wants to predict its stalls.
package data_path_muxs_pkg;

    import cpu_types_pkg::*;

    typedef enum logic [1:0] {
        RUN,
        LU_BUBBLE,
        HALTED
    } hazard_state_t;

    typedef struct packed {
        logic pcEn;
        logic enIfId;
        logic flushIfId;
        logic enIdEx;
        logic flushIdEx;
        logic enExMem;
        logic flushExMem;
        logic enMemWb;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_FREEZE = '{
        pcEn: 1'b0, enIfId: 1'b0, flushIfId: 1'b0, enIdEx: 1'b0,
        flushIdEx: 1'b0, enExMem: 1'b0, flushExMem: 1'b0, enMemWb: 1'b0
    };

    localparam pipe_ctrl_t CTRL_ADVANCE = '{
        pcEn: 1'b1, enIfId: 1'b1, flushIfId: 1'b0, enIdEx: 1'b1,
        flushIdEx: 1'b0, enExMem: 1'b1, flushExMem: 1'b0, enMemWb: 1'b1
    };

    // Hold PC and IF/ID, push a bubble into EX, let older instructions drain.
    localparam pipe_ctrl_t CTRL_HOLD_FRONT = '{
        pcEn: 1'b0, enIfId: 1'b0, flushIfId: 1'b0, enIdEx: 1'b1,
        flushIdEx: 1'b1, enExMem: 1'b1, flushExMem: 1'b0, enMemWb: 1'b1
    };

    // Redirect: everything advances, the two younger instructions are killed.
    localparam pipe_ctrl_t CTRL_REDIRECT = '{
        pcEn: 1'b1, enIfId: 1'b1, flushIfId: 1'b1, enIdEx: 1'b1,
        flushIdEx: 1'b1, enExMem: 1'b1, flushExMem: 1'b0, enMemWb: 1'b1
    };

    function automatic logic loadUseHazard(
        input logic     loadEx,
        input logic     wenEx,
        input regbits_t rtEx,
        input regbits_t rsId,
        input regbits_t rtId,
        input logic     usesRtId
    );
        logic rsMatch;
        logic rtMatch;
        rsMatch = (rtEx == rsId);
        rtMatch = usesRtId && (rtEx == rtId);
        return loadEx && wenEx && (rtEx != '0) && (rsMatch || rtMatch);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance statistics; sticks at all-ones
// instead of wrapping so long runs never report a misleadingly small count.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // NOTE: state updates use non-blocking assignment so every register samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard responder: converts cache handshakes and pipeline fields into
// PC/latch enables and flushes, tracks halt, and counts stalls and bubbles.
module hazard_unit
    import cpu_types_pkg::*;
    import data_path_muxs_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dREN_EX_MEM,
    input  logic             dWEN_EX_MEM,
    input  logic             dREN_ID_EX,
    input  logic             WEN_ID_EX,
    input  regbits_t         Rt_ID_EX,
    input  regbits_t         Rs_IF_ID,
    input  regbits_t         Rt_IF_ID,
    input  logic             uses_rt_IF_ID,
    input  logic             br_taken_EX,
    input  logic             halt_MEM_WB,
    output logic             pc_en,
    output logic             enable_IF_ID,
    output logic             flush_IF_ID,
    output logic             enable_ID_EX,
    output logic             flush_ID_EX,
    output logic             enable_EX_MEM,
    output logic             flush_EX_MEM,
    output logic             enable_MEM_WB,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    hazard_state_t state;
    hazard_state_t nextState;
    pipe_ctrl_t    ctrl;
    logic          dmemWait;
    logic          loadUse;
    logic          bubbleInc;
    logic          stallInc;

    assign dmemWait = (dREN_EX_MEM | dWEN_EX_MEM) & ~dhit;
    assign loadUse  = loadUseHazard(dREN_ID_EX, WEN_ID_EX, Rt_ID_EX,
                                    Rs_IF_ID, Rt_IF_ID, uses_rt_IF_ID);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: every signal written here gets a default first so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        ctrl      = CTRL_FREEZE;
        nextState = state;
        bubbleInc = 1'b0;

        case (state)
            RUN: begin
                if (dmemWait) begin
                    ctrl = CTRL_FREEZE;
                end else if (!ihit) begin
                    ctrl = CTRL_HOLD_FRONT;
                end else if (br_taken_EX) begin
                    // The would-be consumer is flushed, so no bubble is needed.
                    ctrl = CTRL_REDIRECT;
                end else if (loadUse) begin
                    ctrl      = CTRL_HOLD_FRONT;
                    nextState = LU_BUBBLE;
                    bubbleInc = 1'b1;
                end else begin
                    ctrl = CTRL_ADVANCE;
                end
            end
            LU_BUBBLE: begin
                // The load has moved on, so the hazard is not re-evaluated here.
                if (!dmemWait) begin
                    ctrl      = CTRL_ADVANCE;
                    nextState = RUN;
                end
            end
            HALTED: begin
                ctrl = CTRL_FREEZE;
            end
            default: begin
                ctrl      = CTRL_FREEZE;
                nextState = RUN;
            end
        endcase

        if (halt_MEM_WB && !dmemWait) begin
            nextState = HALTED;
        end

        // Outputs follow reset immediately, not at the next edge.
        if (!nRST) begin
            ctrl = CTRL_FREEZE;
        end
    end

    assign pc_en         = ctrl.pcEn;
    assign enable_IF_ID  = ctrl.enIfId;
    assign flush_IF_ID   = ctrl.flushIfId;
    assign enable_ID_EX  = ctrl.enIdEx;
    assign flush_ID_EX   = ctrl.flushIdEx;
    assign enable_EX_MEM = ctrl.enExMem;
    assign flush_EX_MEM  = ctrl.flushExMem;
    assign enable_MEM_WB = ctrl.enMemWb;
    assign halted        = (state == HALTED);

    assign stallInc = nRST & (state != HALTED) & ~ctrl.pcEn;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (stallInc),
        .clr   (1'b0),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_bubble_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (bubbleInc & nRST),
        .clr   (1'b0),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: stimulus pushes expected responses from a
// rule-level model, an independent monitor compares them at the falling edge.
module tb_hazard_unit;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Expected control vector bit order:
    // pc_en, en_IF_ID, fl_IF_ID, en_ID_EX, fl_ID_EX, en_EX_MEM, fl_EX_MEM, en_MEM_WB, halted
    localparam bit [8:0] V_FREEZE  = 9'b000000000;
    localparam bit [8:0] V_HALTED  = 9'b000000001;
    localparam bit [8:0] V_ADVANCE = 9'b110101010;
    localparam bit [8:0] V_HOLD    = 9'b000111010;
    localparam bit [8:0] V_REDIR   = 9'b111111010;

    logic             CLK = 1'b0;
    logic             nRST = 1'b0;
    logic             ihit = 1'b0, dhit = 1'b0;
    logic             dREN_EX_MEM = 1'b0, dWEN_EX_MEM = 1'b0;
    logic             dREN_ID_EX = 1'b0, WEN_ID_EX = 1'b0;
    logic [4:0]       Rt_ID_EX = '0, Rs_IF_ID = '0, Rt_IF_ID = '0;
    logic             uses_rt_IF_ID = 1'b0, br_taken_EX = 1'b0, halt_MEM_WB = 1'b0;
    logic             pc_en, enable_IF_ID, flush_IF_ID, enable_ID_EX, flush_ID_EX;
    logic             enable_EX_MEM, flush_EX_MEM, enable_MEM_WB, halted;
    logic [CNT_W-1:0] stall_cnt, bubble_cnt;

    typedef struct {
        bit rstN, ihit, dhit, ldMem, stMem, ldEx, wenEx;
        int rtEx, rsId, rtId;
        bit usesRt, br, halt;
    } stim_t;

    typedef struct {
        bit [8:0] ctl;
        int       stall;
        int       bubble;
    } exp_t;

    exp_t expQ[$];
    exp_t monExp;
    int   checks = 0;
    int   errors = 0;

    // Reference model state: what the pipeline controller has "remembered".
    bit mHalted = 0;
    bit mPendingBubble = 0;
    int mStall = 0;
    int mBubble = 0;

    hazard_unit #(.CNT_W(CNT_W)) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .ihit          (ihit),
        .dhit          (dhit),
        .dREN_EX_MEM   (dREN_EX_MEM),
        .dWEN_EX_MEM   (dWEN_EX_MEM),
        .dREN_ID_EX    (dREN_ID_EX),
        .WEN_ID_EX     (WEN_ID_EX),
        .Rt_ID_EX      (Rt_ID_EX),
        .Rs_IF_ID      (Rs_IF_ID),
        .Rt_IF_ID      (Rt_IF_ID),
        .uses_rt_IF_ID (uses_rt_IF_ID),
        .br_taken_EX   (br_taken_EX),
        .halt_MEM_WB   (halt_MEM_WB),
        .pc_en         (pc_en),
        .enable_IF_ID  (enable_IF_ID),
        .flush_IF_ID   (flush_IF_ID),
        .enable_ID_EX  (enable_ID_EX),
        .flush_ID_EX   (flush_ID_EX),
        .enable_EX_MEM (enable_EX_MEM),
        .flush_EX_MEM  (flush_EX_MEM),
        .enable_MEM_WB (enable_MEM_WB),
        .halted        (halted),
        .stall_cnt     (stall_cnt),
        .bubble_cnt    (bubble_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, expv, $time);
        end
    endtask

    // Monitor: outputs are combinational, so each cycle's response is sampled mid-cycle.
    always @(negedge CLK) begin
        if (expQ.size() > 0) begin
            monExp = expQ.pop_front();
            check("ctrl", {23'b0, pc_en, enable_IF_ID, flush_IF_ID, enable_ID_EX, flush_ID_EX,
                           enable_EX_MEM, flush_EX_MEM, enable_MEM_WB, halted},
                  {23'b0, monExp.ctl});
            check("stall_cnt", 32'(stall_cnt), monExp.stall);
            check("bubble_cnt", 32'(bubble_cnt), monExp.bubble);
        end
    end

    function automatic int satInc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    // Rule-level model: predicts this cycle's response, then advances its memory.
    task automatic step(input stim_t s, output exp_t e);
        bit memWait, hazard, tookBubble;
        memWait    = (s.ldMem || s.stMem) && !s.dhit;
        hazard     = s.ldEx && s.wenEx && (s.rtEx != 0) &&
                     ((s.rtEx == s.rsId) || (s.usesRt && (s.rtEx == s.rtId)));
        tookBubble = 0;
        e.stall    = s.rstN ? mStall : 0;
        e.bubble   = s.rstN ? mBubble : 0;

        if (!s.rstN)                e.ctl = V_FREEZE;
        else if (mHalted)           e.ctl = V_HALTED;
        else if (memWait)           e.ctl = V_FREEZE;
        else if (mPendingBubble)    e.ctl = V_ADVANCE;
        else if (!s.ihit)           e.ctl = V_HOLD;
        else if (s.br)              e.ctl = V_REDIR;
        else if (hazard) begin
            e.ctl      = V_HOLD;
            tookBubble = 1;
        end else                    e.ctl = V_ADVANCE;

        if (!s.rstN) begin
            mHalted = 0; mPendingBubble = 0; mStall = 0; mBubble = 0;
        end else if (!mHalted) begin
            if (!e.ctl[8]) mStall = satInc(mStall);
            if (tookBubble) begin
                mBubble        = satInc(mBubble);
                mPendingBubble = 1;
            end else if (mPendingBubble && !memWait) begin
                mPendingBubble = 0;
            end
            if (s.halt && !memWait) mHalted = 1;
        end
    endtask

    task automatic drive(input stim_t s);
        exp_t e;
        @(posedge CLK);
        #1;
        nRST          = s.rstN;
        ihit          = s.ihit;
        dhit          = s.dhit;
        dREN_EX_MEM   = s.ldMem;
        dWEN_EX_MEM   = s.stMem;
        dREN_ID_EX    = s.ldEx;
        WEN_ID_EX     = s.wenEx;
        Rt_ID_EX      = 5'(s.rtEx);
        Rs_IF_ID      = 5'(s.rsId);
        Rt_IF_ID      = 5'(s.rtId);
        uses_rt_IF_ID = s.usesRt;
        br_taken_EX   = s.br;
        halt_MEM_WB   = s.halt;
        step(s, e);
        expQ.push_back(e);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rstN = 1; s.ihit = 1; s.dhit = 1; s.ldMem = 0; s.stMem = 0;
        s.ldEx = 0; s.wenEx = 0; s.rtEx = 0; s.rsId = 0; s.rtId = 0;
        s.usesRt = 0; s.br = 0; s.halt = 0;
        return s;
    endfunction

    function automatic stim_t loadUse(input int rt, input int rs, input int rtId, input bit usesRt);
        stim_t s = idle();
        s.ldEx = 1; s.wenEx = 1; s.rtEx = rt; s.rsId = rs; s.rtId = rtId; s.usesRt = usesRt;
        return s;
    endfunction

    function automatic int pickReg();
        int r = int'($urandom_range(0, 3));
        return (r == 3) ? 31 : r;
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        s.rstN   = ($urandom_range(0, 59) != 0);
        s.ihit   = ($urandom_range(0, 5) != 0);
        s.dhit   = ($urandom_range(0, 2) != 0);
        s.ldMem  = ($urandom_range(0, 3) == 0);
        s.stMem  = ($urandom_range(0, 4) == 0);
        s.ldEx   = ($urandom_range(0, 1) == 1);
        s.wenEx  = ($urandom_range(0, 3) != 0);
        s.rtEx   = pickReg();
        s.rsId   = pickReg();
        s.rtId   = pickReg();
        s.usesRt = ($urandom_range(0, 1) == 1);
        s.br     = ($urandom_range(0, 7) == 0);
        s.halt   = 0;
        return s;
    endfunction

    initial begin
        stim_t s;
        stim_t rst;
        rst = idle();
        rst.rstN = 0;

        repeat (2) drive(rst);
        repeat (2) drive(idle());

        // lw $3 in EX, add rs=$3 in ID: bubble, then full advance even if fields linger
        drive(loadUse(3, 3, 0, 0));
        drive(loadUse(3, 3, 0, 0));
        drive(idle());
        // $0 destination never stalls; rt match only counts when rt is read
        drive(loadUse(0, 0, 0, 1));
        drive(loadUse(5, 1, 5, 0));
        drive(loadUse(5, 1, 5, 1));
        drive(idle());

        // Store waiting on dcache for three cycles, then completes
        drive(rst);
        s = idle(); s.stMem = 1; s.dhit = 0;
        repeat (3) drive(s);
        s.dhit = 1;
        drive(s);
        drive(idle());

        // dmem wait during the bubble cycle holds the bubble
        drive(loadUse(7, 7, 0, 0));
        s = idle(); s.ldMem = 1; s.dhit = 0;
        repeat (2) drive(s);
        drive(idle());
        drive(idle());

        // Branch beats load-use: no bubble counted
        s = loadUse(4, 4, 0, 0); s.br = 1;
        drive(s);
        drive(idle());

        // icache miss
        s = idle(); s.ihit = 0;
        repeat (2) drive(s);

        // Reset in the middle of a stall
        s = idle(); s.stMem = 1; s.dhit = 0;
        repeat (2) drive(s);
        drive(rst);
        drive(idle());

        // Saturate both counters
        s = idle(); s.ihit = 0;
        repeat (20) drive(s);
        repeat (18) begin
            drive(loadUse(2, 2, 0, 0));
            drive(idle());
        end

        repeat (600) drive(randStim());

        // Halt is sticky across arbitrary traffic until reset
        drive(rst);
        drive(idle());
        s = idle(); s.halt = 1;
        drive(s);
        repeat (10) begin
            s = randStim();
            s.rstN = 1;
            drive(s);
        end
        drive(rst);
        repeat (2) drive(idle());

        @(negedge CLK);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got=%0d pending expected=0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
